// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared constants for the execute stage and ALU
package rv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SRL  = 4'b0100;
    localparam logic [3:0] ALU_SRA  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_XOR  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational integer ALU for the execute stage
module alu
    import rv_pkg::*;
#(
    parameter int XLEN = rv_pkg::XLEN
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      alu_control,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    // Decode the operation; unused encodings yield zero
    always_comb begin
        result = '0;
        case (alu_control)
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - execute stage with forwarding, branch resolve and EX/MEM register
module ex_mem_stage
    import rv_pkg::*;
#(
    parameter int XLEN   = rv_pkg::XLEN,
    parameter int REG_AW = rv_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic [XLEN-1:0]   id_ex_pc,
    input  logic [XLEN-1:0]   id_ex_output_data1,
    input  logic [XLEN-1:0]   id_ex_output_data_2,
    input  logic [XLEN-1:0]   id_ex_sign_extend_immediate,
    input  logic [REG_AW-1:0] id_ex_register_rs1,
    input  logic [REG_AW-1:0] id_ex_register_rs2,
    input  logic [REG_AW-1:0] id_ex_register_rd,
    input  logic              id_ex_memtoreg,
    input  logic              id_ex_alusrc,
    input  logic              id_ex_memread,
    input  logic              id_ex_memwrite,
    input  logic              id_ex_branch,
    input  logic              id_ex_regwrite_control,
    input  logic [3:0]        id_ex_alu_control,
    input  logic              mem_wb_regwrite,
    input  logic [REG_AW-1:0] mem_wb_rd,
    input  logic [XLEN-1:0]   mem_wb_write_data,
    output logic [XLEN-1:0]   ex_mem_alu_result,
    output logic [XLEN-1:0]   ex_mem_store_data,
    output logic [REG_AW-1:0] ex_mem_register_rd,
    output logic              ex_mem_memtoreg,
    output logic              ex_mem_memread,
    output logic              ex_mem_memwrite,
    output logic              ex_mem_regwrite_control,
    output logic              ex_mem_branch_taken,
    output logic [XLEN-1:0]   ex_mem_branch_target,
    output logic              ex_mem_valid
);

    typedef struct packed {
        logic [XLEN-1:0]   alu_result;
        logic [XLEN-1:0]   store_data;
        logic [XLEN-1:0]   branch_target;
        logic [REG_AW-1:0] rd;
        logic              memtoreg;
        logic              memread;
        logic              memwrite;
        logic              regwrite;
        logic              branch_taken;
        logic              valid;
    } ex_mem_t;

    ex_mem_t         ex_mem_d, ex_mem_q;
    logic [1:0]      fwd_a_sel, fwd_b_sel;
    logic [XLEN-1:0] op_a, rs2_fwd, op_b;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;
    logic            ex_mem_fwd_ok;

    // A load result is not yet available in EX/MEM, so only non-load writers forward from there
    assign ex_mem_fwd_ok = ex_mem_q.regwrite && !ex_mem_q.memtoreg && (ex_mem_q.rd != '0);

    // Pick forwarding sources; the younger EX/MEM producer beats MEM/WB
    always_comb begin
        fwd_a_sel = FWD_REG;
        fwd_b_sel = FWD_REG;
        if (ex_mem_fwd_ok && (ex_mem_q.rd == id_ex_register_rs1))
            fwd_a_sel = FWD_MEM;
        else if (mem_wb_regwrite && (mem_wb_rd != '0) && (mem_wb_rd == id_ex_register_rs1))
            fwd_a_sel = FWD_WB;
        if (ex_mem_fwd_ok && (ex_mem_q.rd == id_ex_register_rs2))
            fwd_b_sel = FWD_MEM;
        else if (mem_wb_regwrite && (mem_wb_rd != '0) && (mem_wb_rd == id_ex_register_rs2))
            fwd_b_sel = FWD_WB;
    end

    // Operand muxes; store data always takes the forwarded rs2, never the immediate
    always_comb begin
        case (fwd_a_sel)
            FWD_MEM: op_a = ex_mem_q.alu_result;
            FWD_WB:  op_a = mem_wb_write_data;
            default: op_a = id_ex_output_data1;
        endcase
        case (fwd_b_sel)
            FWD_MEM: rs2_fwd = ex_mem_q.alu_result;
            FWD_WB:  rs2_fwd = mem_wb_write_data;
            default: rs2_fwd = id_ex_output_data_2;
        endcase
        op_b = id_ex_alusrc ? id_ex_sign_extend_immediate : rs2_fwd;
    end

    alu #(.XLEN(XLEN)) u_alu (
        .a           (op_a),
        .b           (op_b),
        .alu_control (id_ex_alu_control),
        .result      (alu_result),
        .zero        (alu_zero)
    );

    // Assemble the next EX/MEM contents; branches resolve as BEQ on a zero ALU result
    always_comb begin
        ex_mem_d               = '0;
        ex_mem_d.alu_result    = alu_result;
        ex_mem_d.store_data    = rs2_fwd;
        ex_mem_d.branch_target = id_ex_pc + id_ex_sign_extend_immediate;
        ex_mem_d.rd            = id_ex_register_rd;
        ex_mem_d.memtoreg      = id_ex_memtoreg;
        ex_mem_d.memread       = id_ex_memread;
        ex_mem_d.memwrite      = id_ex_memwrite;
        ex_mem_d.regwrite      = id_ex_regwrite_control;
        ex_mem_d.branch_taken  = id_ex_branch && alu_zero;
        ex_mem_d.valid         = id_ex_regwrite_control || id_ex_memwrite || id_ex_branch;
    end

    // EX/MEM register: flush inserts a bubble, stall holds, otherwise capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ex_mem_q <= '0;
        else if (flush)
            ex_mem_q <= '0;
        else if (!stall)
            ex_mem_q <= ex_mem_d;
    end

    assign ex_mem_alu_result       = ex_mem_q.alu_result;
    assign ex_mem_store_data       = ex_mem_q.store_data;
    assign ex_mem_register_rd      = ex_mem_q.rd;
    assign ex_mem_memtoreg         = ex_mem_q.memtoreg;
    assign ex_mem_memread          = ex_mem_q.memread;
    assign ex_mem_memwrite         = ex_mem_q.memwrite;
    assign ex_mem_regwrite_control = ex_mem_q.regwrite;
    assign ex_mem_branch_taken     = ex_mem_q.branch_taken;
    assign ex_mem_branch_target    = ex_mem_q.branch_target;
    assign ex_mem_valid            = ex_mem_q.valid;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - directed scoreboard bench for ex_mem_stage
module tb_ex_mem_stage;

    logic        clk, rst_n, stall, flush;
    logic [31:0] id_ex_pc, id_ex_output_data1, id_ex_output_data_2, id_ex_sign_extend_immediate;
    logic [4:0]  id_ex_register_rs1, id_ex_register_rs2, id_ex_register_rd;
    logic        id_ex_memtoreg, id_ex_alusrc, id_ex_memread, id_ex_memwrite, id_ex_branch;
    logic        id_ex_regwrite_control;
    logic [3:0]  id_ex_alu_control;
    logic        mem_wb_regwrite;
    logic [4:0]  mem_wb_rd;
    logic [31:0] mem_wb_write_data;
    logic [31:0] ex_mem_alu_result, ex_mem_store_data, ex_mem_branch_target;
    logic [4:0]  ex_mem_register_rd;
    logic        ex_mem_memtoreg, ex_mem_memread, ex_mem_memwrite, ex_mem_regwrite_control;
    logic        ex_mem_branch_taken, ex_mem_valid;

    ex_mem_stage dut (
        .clk                         (clk),
        .rst_n                       (rst_n),
        .stall                       (stall),
        .flush                       (flush),
        .id_ex_pc                    (id_ex_pc),
        .id_ex_output_data1          (id_ex_output_data1),
        .id_ex_output_data_2         (id_ex_output_data_2),
        .id_ex_sign_extend_immediate (id_ex_sign_extend_immediate),
        .id_ex_register_rs1          (id_ex_register_rs1),
        .id_ex_register_rs2          (id_ex_register_rs2),
        .id_ex_register_rd           (id_ex_register_rd),
        .id_ex_memtoreg              (id_ex_memtoreg),
        .id_ex_alusrc                (id_ex_alusrc),
        .id_ex_memread               (id_ex_memread),
        .id_ex_memwrite              (id_ex_memwrite),
        .id_ex_branch                (id_ex_branch),
        .id_ex_regwrite_control      (id_ex_regwrite_control),
        .id_ex_alu_control           (id_ex_alu_control),
        .mem_wb_regwrite             (mem_wb_regwrite),
        .mem_wb_rd                   (mem_wb_rd),
        .mem_wb_write_data           (mem_wb_write_data),
        .ex_mem_alu_result           (ex_mem_alu_result),
        .ex_mem_store_data           (ex_mem_store_data),
        .ex_mem_register_rd          (ex_mem_register_rd),
        .ex_mem_memtoreg             (ex_mem_memtoreg),
        .ex_mem_memread              (ex_mem_memread),
        .ex_mem_memwrite             (ex_mem_memwrite),
        .ex_mem_regwrite_control     (ex_mem_regwrite_control),
        .ex_mem_branch_taken         (ex_mem_branch_taken),
        .ex_mem_branch_target        (ex_mem_branch_target),
        .ex_mem_valid                (ex_mem_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] sd;
        logic [31:0] tgt;
        logic [4:0]  rd;
        logic [3:0]  ctrl;   // {memtoreg, memread, memwrite, regwrite}
        logic        bt;
        logic        v;
        logic        data_chk;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100, OP_SRA = 4'b0101, OP_SUB = 4'b0110, OP_SLT = 4'b0111;
    localparam logic [3:0] OP_XOR = 4'b1000, OP_SLTU = 4'b1001, OP_NOR = 4'b1100;

    // ctl = {alusrc, memtoreg, memread, memwrite, branch, regwrite}
    task automatic drive(input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic [5:0] ctl);
        id_ex_alu_control           = op;
        id_ex_output_data1          = d1;
        id_ex_output_data_2         = d2;
        id_ex_sign_extend_immediate = imm;
        id_ex_pc                    = pc;
        id_ex_register_rs1          = rs1;
        id_ex_register_rs2          = rs2;
        id_ex_register_rd           = rd;
        {id_ex_alusrc, id_ex_memtoreg, id_ex_memread, id_ex_memwrite, id_ex_branch,
         id_ex_regwrite_control}    = ctl;
    endtask

    task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
        mem_wb_regwrite   = we;
        mem_wb_rd         = rd;
        mem_wb_write_data = data;
    endtask

    task automatic expect_out(input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] tgt,
                              input logic [4:0] rd, input logic [3:0] ctrl, input logic bt,
                              input logic v, input logic data_chk);
        exp_t e;
        e.alu = alu; e.sd = sd; e.tgt = tgt; e.rd = rd; e.ctrl = ctrl;
        e.bt = bt; e.v = v; e.data_chk = data_chk;
        sb.push_back(e);
    endtask

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_now(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s scoreboard empty got %h expected entry", tag, ex_mem_alu_result);
        end else begin
            e = sb.pop_front();
            if (e.data_chk) begin
                cmp({tag, ".alu"}, ex_mem_alu_result, e.alu);
                cmp({tag, ".sd"},  ex_mem_store_data, e.sd);
                cmp({tag, ".tgt"}, ex_mem_branch_target, e.tgt);
                cmp({tag, ".rd"},  {27'd0, ex_mem_register_rd}, {27'd0, e.rd});
            end
            cmp({tag, ".ctrl"}, {28'd0, ex_mem_memtoreg, ex_mem_memread, ex_mem_memwrite,
                                 ex_mem_regwrite_control}, {28'd0, e.ctrl});
            cmp({tag, ".bt"}, {31'd0, ex_mem_branch_taken}, {31'd0, e.bt});
            cmp({tag, ".v"},  {31'd0, ex_mem_valid}, {31'd0, e.v});
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        #1;
        check_now(tag);
    endtask

    logic [3:0]  t_op  [15] = '{OP_SLT, OP_SLTU, OP_SRA, OP_SRL, OP_SLL, OP_SLL, OP_ADD, OP_SUB,
                                OP_XOR, OP_NOR, OP_AND, OP_OR, 4'b1111, OP_SLT, OP_SLTU};
    logic [31:0] t_a   [15] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'h1,
                                32'h1, 32'hFFFFFFFF, 32'h0, 32'hF0F0F0F0, 32'hF0F0F0F0,
                                32'hF0F0F0F0, 32'hF0F0F0F0, 32'h12345678, 32'h1, 32'h1};
    logic [31:0] t_b   [15] = '{32'h1, 32'h1, 32'd31, 32'd31, 32'd31, 32'd33, 32'h1, 32'h1,
                                32'hFF00FF00, 32'h0F0F0000, 32'hFF00FF00, 32'h0F0F0000,
                                32'h9ABCDEF0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] t_exp [15] = '{32'h1, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h80000000, 32'h2, 32'h0,
                                32'hFFFFFFFF, 32'h0FF00FF0, 32'h00000F0F, 32'hF000F000,
                                32'hFFFFF0F0, 32'h0, 32'h0, 32'h1};

    initial begin
        stall = 1'b0;
        flush = 1'b0;
        wb(1'b0, 5'd0, 32'd0);
        rst_n = 1'b1;
        drive(OP_ADD, 32'd1, 32'd2, 32'd8, 32'h40, 5'd2, 5'd3, 5'd1, 6'b000111);
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expect_out(32'd0, 32'd0, 32'd0, 5'd0, 4'b0000, 1'b0, 1'b0, 1'b1);
        check_now("reset");

        @(negedge clk);
        rst_n = 1'b1;
        drive(OP_ADD, 32'd5, 32'd7, 32'd0, 32'd0, 5'd2, 5'd3, 5'd1, 6'b000001);
        expect_out(32'd12, 32'd7, 32'd0, 5'd1, 4'b0001, 1'b0, 1'b1, 1'b1);
        step("add_first");

        drive(OP_ADD, 32'd15, 32'd5, 32'd0, 32'd0, 5'd4, 5'd5, 5'd3, 6'b000001);
        expect_out(32'd20, 32'd5, 32'd0, 5'd3, 4'b0001, 1'b0, 1'b1, 1'b1);
        step("add_rd3");

        drive(OP_SUB, 32'd0, 32'd4, 32'd0, 32'd0, 5'd3, 5'd6, 5'd7, 6'b000001);
        wb(1'b1, 5'd3, 32'd99);
        expect_out(32'd16, 32'd4, 32'd0, 5'd7, 4'b0001, 1'b0, 1'b1, 1'b1);
        step("fwd_exmem_prio");
        wb(1'b0, 5'd0, 32'd0);

        drive(OP_ADD, 32'd100, 32'd1, 32'd0, 32'd0, 5'd8, 5'd9, 5'd0, 6'b000001);
        expect_out(32'd101, 32'd1, 32'd0, 5'd0, 4'b0001, 1'b0, 1'b1, 1'b1);
        step("add_rd0");

        drive(OP_ADD, 32'd0, 32'd3, 32'd0, 32'd0, 5'd0, 5'd10, 5'd11, 6'b000001);
        wb(1'b1, 5'd0, 32'd77);
        expect_out(32'd3, 32'd3, 32'd0, 5'd11, 4'b0001, 1'b0, 1'b1, 1'b1);
        step("no_fwd_x0");
        wb(1'b0, 5'd0, 32'd0);

        drive(OP_ADD, 32'h40, 32'h9, 32'h4, 32'd0, 5'd13, 5'd14, 5'd12, 6'b111001);
        expect_out(32'h44, 32'h9, 32'h4, 5'd12, 4'b1101, 1'b0, 1'b1, 1'b1);
        step("load_alusrc_sd");

        drive(OP_ADD, 32'd1, 32'd2, 32'd0, 32'd0, 5'd12, 5'd15, 5'd16, 6'b000001);
        wb(1'b1, 5'd12, 32'd55);
        expect_out(32'd57, 32'd2, 32'd0, 5'd16, 4'b0001, 1'b0, 1'b1, 1'b1);
        step("no_fwd_memtoreg");
        wb(1'b0, 5'd0, 32'd0);

        drive(OP_SUB, 32'h10, 32'h10, 32'h20, 32'h100, 5'd17, 5'd18, 5'd0, 6'b000010);
        expect_out(32'h0, 32'h10, 32'h120, 5'd0, 4'b0000, 1'b1, 1'b1, 1'b1);
        step("beq_taken");

        drive(OP_SUB, 32'h10, 32'h11, 32'h20, 32'h100, 5'd17, 5'd18, 5'd0, 6'b000010);
        expect_out(32'hFFFFFFFF, 32'h11, 32'h120, 5'd0, 4'b0000, 1'b0, 1'b1, 1'b1);
        step("beq_not_taken");

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(OP_ADD, 32'd1 + i, 32'd2 + i, 32'd0, 32'd0, 5'd19, 5'd20, 5'd21, 6'b000101);
            expect_out(32'hFFFFFFFF, 32'h11, 32'h120, 5'd0, 4'b0000, 1'b0, 1'b1, 1'b1);
            step("stall_hold");
        end
        stall = 1'b0;

        drive(OP_ADD, 32'hFFFFFFFF, 32'h1, 32'd0, 32'd0, 5'd22, 5'd23, 5'd20, 6'b000001);
        expect_out(32'h0, 32'h1, 32'd0, 5'd20, 4'b0001, 1'b0, 1'b1, 1'b1);
        step("add_wrap");

        stall = 1'b1;
        flush = 1'b1;
        drive(OP_ADD, 32'd3, 32'd4, 32'd0, 32'd0, 5'd22, 5'd23, 5'd24, 6'b000111);
        expect_out(32'd0, 32'd0, 32'd0, 5'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
        step("flush_over_stall");
        stall = 1'b0;
        flush = 1'b0;

        for (int i = 0; i < 15; i++) begin
            drive(t_op[i], t_a[i], t_b[i], 32'd0, 32'd0, 5'd25, 5'd26, 5'd27, 6'b000001);
            expect_out(t_exp[i], t_b[i], 32'd0, 5'd27, 4'b0001, 1'b0, 1'b1, 1'b1);
            step($sformatf("alu_tbl%0d", i));
        end

        #2 rst_n = 1'b0;
        #1;
        expect_out(32'd0, 32'd0, 32'd0, 5'd0, 4'b0000, 1'b0, 1'b0, 1'b1);
        check_now("async_reset");

        @(negedge clk);
        rst_n = 1'b1;
        drive(OP_ADD, 32'd3, 32'd4, 32'h20, 32'hFFFFFFF0, 5'd1, 5'd2, 5'd5, 6'b000001);
        expect_out(32'd7, 32'd4, 32'h10, 5'd5, 4'b0001, 1'b0, 1'b1, 1'b1);
        step("after_release_tgt_wrap");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
